vse_store_unit: RTL and testbench
=================================

Name: vse_store_unit

Overview:
- Store-side companion of the softmax test harness's vector-load path. Decodes a unit-stride vse32 instruction and reads the source vector register through a register-file read port.
- Drains the register as a sequence of 32-bit element writes over a valid/ready memory write channel, then pulses done.
- Sits between the instruction stream and the memory model: the load path fills vreg from memory; this block empties vreg to memory.

Parameters:
- VLEN, 1024, vector register width in bits.
- ELEN, 32, element width in bits. NUM_ELEM = VLEN/ELEN = 32 (derived, not overridable).
- ADDR_W, 64, memory address width.

Ports:
- clock  input  1  sole clock.
- reset  input  1  synchronous, active-high reset.
- instr_valid  input  1  instruction present.
- instr  input  32  RISC-V instruction word.
- instr_ready  output  1  unit can accept an instruction.
- base_addr  input  ADDR_W  value of x[rs1], sampled on accept.
- vl  input  6  active element count 0..32, sampled on accept.
- v0_mask  input  NUM_ELEM  mask register bits, sampled on accept.
- vreg_raddr  output  5  register-file read index.
- vreg_rdata  input  VLEN  combinational read data for vreg_raddr; element i = bits [i*32 +: 32].
- mem_wvalid  output  1  write beat valid.
- mem_wready  input  1  memory accepts beat.
- mem_waddr  output  ADDR_W  byte address of beat.
- mem_wdata  output  ELEN  beat data.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Decode: vse32 iff instr[6:0]==7'b010_0111, instr[14:12]==3'b110, instr[27:26]==2'b00 (unit stride). vs3 = instr[11:7]. vm = instr[25].
- Reset values: state IDLE, instr_ready=1, mem_wvalid=0, done=0, vreg_raddr=0, mem_waddr=0, mem_wdata=0, idx=0.
- FSM states: IDLE, READ, SEND, DONE.
- IDLE:
  - instr_ready=1.
  - On instr_valid with vse32: latch vs3, base, vl, vm, mask; go to READ.
  - On instr_valid with any other instruction: consume it with no effect and no done pulse; stay in IDLE.
- READ (1 cycle):
  - vreg_raddr = latched vs3; capture vreg_rdata into a VLEN data buffer; idx=0.
  - Go to SEND, or to DONE if vl==0.
- SEND (one element index per cycle or stall):
  - Element idx is active iff idx<vl and (vm==1 or mask[idx]==1).
  - Active: mem_wvalid=1, mem_waddr=base+4*idx (mod 2^ADDR_W, wraps silently), mem_wdata=buffer[idx*32 +: 32]. Hold all three stable until mem_wready; advance idx on handshake.
  - Inactive: mem_wvalid=0 for exactly one cycle; idx advances.
  - Go to DONE after index vl-1 retires, whether it ended by handshake or by skip. Indices >= vl are never visited.
- DONE: done=1 for one cycle; next state IDLE.
- instr_ready=0 in READ/SEND/DONE. No overlap between instructions.
- Latency: accept at edge T; READ in cycle T+1; first beat offered in T+2. With mem_wready tied high and all vl elements active, done asserts in cycle T+2+vl. With vl==0, done asserts in T+2.
- The buffer isolates the register-file contents: later writes to vs3 do not affect data already in flight.
- mem_wready asserted while mem_wvalid=0 is ignored.
- Synchronous reset mid-operation: return to IDLE next edge with reset values. No further beats; no done for the aborted instruction.

Decomposition:
- Shared package vec_pkg: VLEN, ELEN, NUM_ELEM, opcode constant OP_STORE_FP=7'b010_0111, width code W32=3'b110, state enum {IDLE, READ, SEND, DONE}.
- The load path imports the same package.
- One natural sub-module, vse_decode: combinational instruction decode producing is_vse32, vs3, vm.

Test Plan:
- vse32 v5 (vm=1), vl=32, base=0x1000, vreg[5] element i = 0xA000_0000+i, mem_wready=1 -> 32 beats at 0x1000..0x107C with matching data; done in cycle T+34; no beat in cycles T and T+1.
- Same as above with mem_wready low for 3 cycles on beat 4 -> mem_waddr=0x1010 and mem_wdata=0xA000_0004 held stable throughout the stall; done delayed by 3 cycles.
- vm=0, v0_mask=0x0000_0005, vl=4 -> beats only at base+0 and base+8; 4 SEND cycles total; single done pulse.
- vl=0 -> no mem_wvalid; done in cycle T+2.
- Non-vse instruction (a vle32 encoding) presented -> accepted in IDLE; no beats, no done.
- Reset asserted during beat 10 of 32 -> outputs at reset values next cycle; a new vse32 afterwards starts at element 0.

Source files
------------

// File: rtl/vec_pkg.sv
// Shared vector-unit definitions used by both the vector load and store paths.
package vec_pkg;

  localparam int VLEN     = 1024;
  localparam int ELEN     = 32;
  localparam int NUM_ELEM = VLEN / ELEN;
  localparam int ADDR_W   = 64;

  localparam logic [6:0] OP_STORE_FP = 7'b010_0111;
  localparam logic [2:0] W32         = 3'b110;
  localparam logic [1:0] MOP_UNIT    = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_e;

  // An element is written when it lies inside vl and is either unmasked or enabled in v0.
  function automatic logic elem_active(input logic [5:0]          idx,
                                       input logic [5:0]          vl,
                                       input logic                vm,
                                       input logic [NUM_ELEM-1:0] mask);
    return (idx < vl) && (vm || mask[idx[4:0]]);
  endfunction

endpackage

// File: rtl/vse_decode.sv
// Combinational decode of a unit-stride vse32 store: recognises the encoding and
// extracts the source register and mask-enable bit.
module vse_decode (
  input  logic [31:0] instr_i,
  output logic        is_vse32_o,
  output logic [4:0]  vs3_o,
  output logic        vm_o
);
  import vec_pkg::*;

  logic unused_bits;

  assign is_vse32_o = (instr_i[6:0] == OP_STORE_FP) &&
                      (instr_i[14:12] == W32) &&
                      (instr_i[27:26] == MOP_UNIT);
  assign vs3_o      = instr_i[11:7];
  assign vm_o       = instr_i[25];

  // nf, mew, sumop and rs1 do not influence this unit.
  assign unused_bits = ^{instr_i[31:28], instr_i[24:15]};

endmodule

// File: rtl/vse_store_unit.sv
// Unit-stride vse32 store engine: snapshots a vector register into a private buffer
// and drains it element by element over a valid/ready memory write channel.
module vse_store_unit #(
  parameter int VLEN   = 1024,
  parameter int ELEN   = 32,
  parameter int ADDR_W = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   instr_valid,
  input  logic [31:0]            instr,
  output logic                   instr_ready,
  input  logic [ADDR_W-1:0]      base_addr,
  input  logic [5:0]             vl,
  input  logic [VLEN/ELEN-1:0]   v0_mask,
  output logic [4:0]             vreg_raddr,
  input  logic [VLEN-1:0]        vreg_rdata,
  output logic                   mem_wvalid,
  input  logic                   mem_wready,
  output logic [ADDR_W-1:0]      mem_waddr,
  output logic [ELEN-1:0]        mem_wdata,
  output logic                   done
);
  import vec_pkg::*;

  localparam int N_ELEM = VLEN / ELEN;

  state_e              state_q, state_d;
  logic [5:0]          idx_q, idx_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [5:0]          vl_q, vl_d;
  logic                vm_q, vm_d;
  logic [N_ELEM-1:0]   mask_q, mask_d;
  logic [VLEN-1:0]     buf_q, buf_d;
  logic [4:0]          raddr_q, raddr_d;
  logic                ready_q, ready_d;
  logic                wvalid_q, wvalid_d;
  logic                done_q, done_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [ELEN-1:0]     wdata_q, wdata_d;

  logic                dec_is_vse32;
  logic [4:0]          dec_vs3;
  logic                dec_vm;

  vse_decode u_decode (
    .instr_i    (instr),
    .is_vse32_o (dec_is_vse32),
    .vs3_o      (dec_vs3),
    .vm_o       (dec_vm)
  );

  // Next-state logic: sequencing, operand latching and buffer capture.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    base_d  = base_q;
    vl_d    = vl_q;
    vm_d    = vm_q;
    mask_d  = mask_q;
    buf_d   = buf_q;
    raddr_d = raddr_q;
    case (state_q)
      IDLE: begin
        if (instr_valid && dec_is_vse32) begin
          state_d = READ;
          base_d  = base_addr;
          vl_d    = vl;
          vm_d    = dec_vm;
          mask_d  = v0_mask;
          raddr_d = dec_vs3;
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        buf_d = vreg_rdata;
        idx_d = 6'd0;
        if (vl_q == 6'd0) begin
          state_d = DONE;
        end else begin
          state_d = SEND;
        end
      end
      SEND: begin
        // A skipped element retires immediately; an offered one waits for the handshake.
        if (!wvalid_q || mem_wready) begin
          if ((idx_q + 6'd1) == vl_q) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end else begin
          state_d = SEND;
        end
      end
      DONE: begin
        state_d = IDLE;
        idx_d   = 6'd0;
      end
      default: begin
        state_d = IDLE;
        idx_d   = 6'd0;
      end
    endcase
  end

  // Output pre-computation so every interface output comes straight from a flop.
  always_comb begin
    ready_d  = (state_d == IDLE);
    done_d   = (state_d == DONE);
    wvalid_d = (state_d == SEND) && elem_active(idx_d, vl_q, vm_q, mask_q);
    if (wvalid_d) begin
      waddr_d = base_q + {{(ADDR_W-8){1'b0}}, idx_d, 2'b00};
      wdata_d = buf_d[ELEN*int'(idx_d[4:0]) +: ELEN];
    end else begin
      waddr_d = {ADDR_W{1'b0}};
      wdata_d = {ELEN{1'b0}};
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= 6'd0;
      base_q   <= {ADDR_W{1'b0}};
      vl_q     <= 6'd0;
      vm_q     <= 1'b0;
      mask_q   <= {N_ELEM{1'b0}};
      buf_q    <= {VLEN{1'b0}};
      raddr_q  <= 5'd0;
      ready_q  <= 1'b1;
      wvalid_q <= 1'b0;
      done_q   <= 1'b0;
      waddr_q  <= {ADDR_W{1'b0}};
      wdata_q  <= {ELEN{1'b0}};
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      base_q   <= base_d;
      vl_q     <= vl_d;
      vm_q     <= vm_d;
      mask_q   <= mask_d;
      buf_q    <= buf_d;
      raddr_q  <= raddr_d;
      ready_q  <= ready_d;
      wvalid_q <= wvalid_d;
      done_q   <= done_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign instr_ready = ready_q;
  assign vreg_raddr  = raddr_q;
  assign mem_wvalid  = wvalid_q;
  assign mem_waddr   = waddr_q;
  assign mem_wdata   = wdata_q;
  assign done        = done_q;

endmodule

// File: tb/tb_vse_store_unit.sv
// Directed self-checking bench for vse_store_unit.
module tb_vse_store_unit;

  logic          clock = 1'b0;
  logic          reset;
  logic          instr_valid;
  logic [31:0]   instr;
  logic          instr_ready;
  logic [63:0]   base_addr;
  logic [5:0]    vl;
  logic [31:0]   v0_mask;
  logic [4:0]    vreg_raddr;
  logic [1023:0] vreg_rdata;
  logic          mem_wvalid;
  logic          mem_wready;
  logic [63:0]   mem_waddr;
  logic [31:0]   mem_wdata;
  logic          done;

  logic [1023:0] vrf [32];
  assign vreg_rdata = vrf[vreg_raddr];

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  int          obs_n;
  logic [63:0] obs_addr [64];
  logic [31:0] obs_data [64];
  int          done_cyc;
  int          done_cnt;
  int          early;
  int          unstable;

  vse_store_unit #(.VLEN(1024), .ELEN(32), .ADDR_W(64)) dut (
    .clock       (clock),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .base_addr   (base_addr),
    .vl          (vl),
    .v0_mask     (v0_mask),
    .vreg_raddr  (vreg_raddr),
    .vreg_rdata  (vreg_rdata),
    .mem_wvalid  (mem_wvalid),
    .mem_wready  (mem_wready),
    .mem_waddr   (mem_waddr),
    .mem_wdata   (mem_wdata),
    .done        (done)
  );

  function automatic logic [31:0] enc(input logic [6:0] op, input logic [1:0] mop,
                                      input logic vm, input logic [4:0] vs3);
    return {3'b000, 1'b0, mop, vm, 5'b00000, 5'd10, 3'b110, vs3, op};
  endfunction

  function automatic logic [31:0] elem_val(input int r, input int i);
    return 32'hA000_0000 + ((32'(r) ^ 32'd5) << 16) + 32'(i);
  endfunction

  task automatic init_vrf();
    for (int r = 0; r < 32; r++)
      for (int i = 0; i < 32; i++)
        vrf[r][i*32 +: 32] = elem_val(r, i);
  endtask

  // Issues one instruction in cycle T and records beats/done for the cycles that follow.
  task automatic run_store(input logic [31:0] ins, input logic [63:0] base, input logic [5:0] vlv,
                           input logic [31:0] mask, input int stall_beat, input int stall_len,
                           input int reset_beat);
    int stalled = 0;
    logic pv = 1'b0;
    logic [63:0] pa = 64'd0;
    logic [31:0] pd = 32'd0;
    obs_n = 0; done_cyc = -1; done_cnt = 0; early = 0; unstable = 0;
    init_vrf();
    instr = ins; base_addr = base; vl = vlv; v0_mask = mask;
    instr_valid = 1'b1; mem_wready = 1'b1;
    if (mem_wvalid) early++;
    for (int c = 1; c <= 80; c++) begin
      @(posedge clock); #1;
      instr_valid = 1'b0; instr = 32'h0; base_addr = 64'hDEAD_BEEF_0000_0000;
      vl = 6'd17; v0_mask = 32'h0;
      if (c == 2) vrf[ins[11:7]] = '0;
      if (c == 1 && mem_wvalid) early++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (pv && (!mem_wvalid || mem_waddr !== pa || mem_wdata !== pd)) unstable++;
      pv = 1'b0;
      if (mem_wvalid) begin
        if (reset_beat >= 0 && obs_n == reset_beat) begin
          reset = 1'b1;
          mem_wready = 1'b1;
          return;
        end
        if (obs_n == stall_beat && stalled < stall_len) begin
          mem_wready = 1'b0; stalled++; pv = 1'b1; pa = mem_waddr; pd = mem_wdata;
        end else begin
          mem_wready = 1'b1;
          if (obs_n < 64) begin
            obs_addr[obs_n] = mem_waddr;
            obs_data[obs_n] = mem_wdata;
          end
          obs_n++;
        end
      end else begin
        mem_wready = c[0];
      end
      if (done_cyc >= 0 && c >= done_cyc + 3) break;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; instr_valid = 1'b0; instr = 32'h0; mem_wready = 1'b0;
    base_addr = 64'h0; vl = 6'd0; v0_mask = 32'h0;
    init_vrf();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    n_vec++; if (instr_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", instr_ready); end
    n_vec++; if (mem_wvalid !== 1'b0) begin n_err++; $display("FAIL reset_wvalid got %b want 0", mem_wvalid); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    n_vec++; if (vreg_raddr !== 5'd0 || mem_waddr !== 64'd0 || mem_wdata !== 32'd0) begin
      n_err++; $display("FAIL reset_regs got raddr=%0d addr=%h data=%h want 0/0/0", vreg_raddr, mem_waddr, mem_wdata);
    end
  endtask

  task automatic test_full();
    run_store(enc(7'b010_0111, 2'b00, 1'b1, 5'd5), 64'h1000, 6'd32, 32'h0, -1, 0, -1);
    n_vec++; if (early !== 0) begin n_err++; $display("FAIL full_early got %0d want 0", early); end
    n_vec++; if (obs_n !== 32) begin n_err++; $display("FAIL full_beats got %0d want 32", obs_n); end
    for (int i = 0; i < 32; i++) begin
      n_vec++;
      if (obs_addr[i] !== 64'h1000 + 64'(4*i) || obs_data[i] !== 32'hA000_0000 + 32'(i)) begin
        n_err++;
        $display("FAIL full_beat%0d got %h/%h want %h/%h", i, obs_addr[i], obs_data[i],
                 64'h1000 + 64'(4*i), 32'hA000_0000 + 32'(i));
      end
    end
    n_vec++; if (done_cyc !== 34) begin n_err++; $display("FAIL full_done_cycle got %0d want 34", done_cyc); end
    n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL full_done_pulses got %0d want 1", done_cnt); end
  endtask

  task automatic test_stall();
    run_store(enc(7'b010_0111, 2'b00, 1'b1, 5'd5), 64'h1000, 6'd32, 32'h0, 4, 3, -1);
    n_vec++; if (unstable !== 0) begin n_err++; $display("FAIL stall_stable got %0d changes want 0", unstable); end
    n_vec++; if (obs_addr[4] !== 64'h1010 || obs_data[4] !== 32'hA000_0004) begin
      n_err++; $display("FAIL stall_beat4 got %h/%h want 1010/a0000004", obs_addr[4], obs_data[4]);
    end
    n_vec++; if (obs_n !== 32) begin n_err++; $display("FAIL stall_beats got %0d want 32", obs_n); end
    n_vec++; if (done_cyc !== 37) begin n_err++; $display("FAIL stall_done_cycle got %0d want 37", done_cyc); end
  endtask

  task automatic test_mask();
    run_store(enc(7'b010_0111, 2'b00, 1'b0, 5'd5), 64'h2000, 6'd4, 32'h0000_0005, -1, 0, -1);
    n_vec++; if (obs_n !== 2) begin n_err++; $display("FAIL mask_beats got %0d want 2", obs_n); end
    n_vec++; if (obs_addr[0] !== 64'h2000 || obs_data[0] !== 32'hA000_0000) begin
      n_err++; $display("FAIL mask_beat0 got %h/%h want 2000/a0000000", obs_addr[0], obs_data[0]);
    end
    n_vec++; if (obs_addr[1] !== 64'h2008 || obs_data[1] !== 32'hA000_0002) begin
      n_err++; $display("FAIL mask_beat1 got %h/%h want 2008/a0000002", obs_addr[1], obs_data[1]);
    end
    n_vec++; if (done_cyc !== 6) begin n_err++; $display("FAIL mask_done_cycle got %0d want 6", done_cyc); end
    n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL mask_done_pulses got %0d want 1", done_cnt); end
  endtask

  task automatic test_vl0();
    run_store(enc(7'b010_0111, 2'b00, 1'b1, 5'd5), 64'h4000, 6'd0, 32'h0, -1, 0, -1);
    n_vec++; if (obs_n !== 0) begin n_err++; $display("FAIL vl0_beats got %0d want 0", obs_n); end
    n_vec++; if (done_cyc !== 2) begin n_err++; $display("FAIL vl0_done_cycle got %0d want 2", done_cyc); end
  endtask

  task automatic test_nonvse();
    run_store(enc(7'b000_0111, 2'b00, 1'b1, 5'd5), 64'h5000, 6'd8, 32'h0, -1, 0, -1);
    n_vec++; if (obs_n !== 0 || done_cnt !== 0) begin
      n_err++; $display("FAIL nonvse_vle got beats=%0d dones=%0d want 0/0", obs_n, done_cnt);
    end
    n_vec++; if (instr_ready !== 1'b1) begin n_err++; $display("FAIL nonvse_ready got %b want 1", instr_ready); end
    run_store(enc(7'b010_0111, 2'b10, 1'b1, 5'd5), 64'h5000, 6'd8, 32'h0, -1, 0, -1);
    n_vec++; if (obs_n !== 0 || done_cnt !== 0) begin
      n_err++; $display("FAIL nonvse_strided got beats=%0d dones=%0d want 0/0", obs_n, done_cnt);
    end
  endtask

  task automatic test_wrap();
    run_store(enc(7'b010_0111, 2'b00, 1'b1, 5'd7), 64'hFFFF_FFFF_FFFF_FFF8, 6'd3, 32'h0, -1, 0, -1);
    n_vec++; if (obs_n !== 3) begin n_err++; $display("FAIL wrap_beats got %0d want 3", obs_n); end
    n_vec++; if (obs_addr[2] !== 64'h0 || obs_data[2] !== elem_val(7, 2)) begin
      n_err++; $display("FAIL wrap_beat2 got %h/%h want 0/%h", obs_addr[2], obs_data[2], elem_val(7, 2));
    end
    n_vec++; if (obs_addr[1] !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      n_err++; $display("FAIL wrap_beat1 got %h want fffffffffffffffc", obs_addr[1]);
    end
    n_vec++; if (done_cyc !== 5) begin n_err++; $display("FAIL wrap_done_cycle got %0d want 5", done_cyc); end
  endtask

  task automatic test_reset_mid();
    run_store(enc(7'b010_0111, 2'b00, 1'b1, 5'd5), 64'h1000, 6'd32, 32'h0, -1, 0, 10);
    n_vec++; if (obs_n !== 10) begin n_err++; $display("FAIL rstmid_reached got %0d want 10", obs_n); end
    @(posedge clock); #1;
    reset = 1'b0;
    n_vec++; if (mem_wvalid !== 1'b0 || done !== 1'b0 || instr_ready !== 1'b1) begin
      n_err++; $display("FAIL rstmid_ctrl got wvalid=%b done=%b ready=%b want 0/0/1", mem_wvalid, done, instr_ready);
    end
    n_vec++; if (mem_waddr !== 64'd0 || mem_wdata !== 32'd0 || vreg_raddr !== 5'd0) begin
      n_err++; $display("FAIL rstmid_regs got %h/%h/%0d want 0/0/0", mem_waddr, mem_wdata, vreg_raddr);
    end
    run_store(enc(7'b010_0111, 2'b00, 1'b1, 5'd5), 64'h3000, 6'd2, 32'h0, -1, 0, -1);
    n_vec++; if (early !== 0 || obs_n !== 2) begin
      n_err++; $display("FAIL rstmid_restart got early=%0d beats=%0d want 0/2", early, obs_n);
    end
    n_vec++; if (obs_addr[0] !== 64'h3000 || obs_data[0] !== 32'hA000_0000) begin
      n_err++; $display("FAIL rstmid_beat0 got %h/%h want 3000/a0000000", obs_addr[0], obs_data[0]);
    end
    n_vec++; if (done_cyc !== 4 || done_cnt !== 1) begin
      n_err++; $display("FAIL rstmid_done got cyc=%0d cnt=%0d want 4/1", done_cyc, done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_full();
    test_stall();
    test_mask();
    test_vl0();
    test_nonvse();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
